// File: rtl/audio_level_detector_pkg.sv
// Shared types and constants for the audio level detector and the display path.
// Provides the voice-activity state encoding and the saturating magnitude helper.
package audio_pkg;

    localparam int SAMPLE_W  = 32;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } vad_state_t;

    // |x| for two's complement; the most negative code has no positive twin.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
        if (!x[SAMPLE_W-1])
            return x;
        else if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        else
            return -x;
    endfunction

endpackage

// File: rtl/audio_level_detector_if.sv
// Sample stream in, level/peak/voice status out.
// The master drives samples; the detector is the slave.
interface audio_level_detector_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [DIGIT_W-1:0]  level_digit;
    logic [SAMPLE_W-1:0] peak_mag;
    logic                voice_active;
    logic                level_valid;

    modport master (
        output sample_in, sample_valid,
        input  level_digit, peak_mag, voice_active, level_valid
    );

    modport slave (
        input  sample_in, sample_valid,
        output level_digit, peak_mag, voice_active, level_valid
    );

endinterface

// File: rtl/audio_level_detector_level_quantizer.sv
// Maps a magnitude to a 0..MAX_DIGIT digit: the highest k with value >= k*THRESH_STEP.
// Thresholds are compared at widened width so k*THRESH_STEP never wraps.
module level_quantizer
    import audio_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] THRESH_STEP = 32'h0100_0000
) (
    input  logic [SAMPLE_W-1:0] value,
    output logic [DIGIT_W-1:0]  digit
);

    localparam int CMP_W = SAMPLE_W + 4;

    always_comb begin
        // NOTE: default first so every path assigns digit; no latch is inferred.
        digit = '0;
        for (int k = 1; k <= MAX_DIGIT; k++) begin
            if (CMP_W'(value) >= CMP_W'(k) * CMP_W'(THRESH_STEP))
                digit = DIGIT_W'(k);
        end
    end

endmodule

// File: rtl/audio_level_detector.sv
// Peak envelope with hold/decay, quantized level digit, and a debounced
// voice-activity FSM driven by the instantaneous sample digit.
module audio_level_detector
    import audio_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] THRESH_STEP = 32'h0100_0000,
    parameter int ON_LEVEL    = 3,
    parameter int OFF_LEVEL   = 2,
    parameter int ATTACK_N    = 4,
    parameter int RELEASE_N   = 8,
    parameter int HOLD_N      = 16,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_level_detector_if.slave bus
);

    localparam int HOLD_W = $clog2(HOLD_N + 1);
    localparam int CNT_MAX = (ATTACK_N > RELEASE_N) ? ATTACK_N : RELEASE_N;
    localparam int CNT_W  = $clog2(CNT_MAX + 1);

    localparam logic [DIGIT_W-1:0] ON_D      = DIGIT_W'(ON_LEVEL);
    localparam logic [DIGIT_W-1:0] OFF_D     = DIGIT_W'(OFF_LEVEL);
    localparam logic [CNT_W-1:0]   ATTACK_C  = CNT_W'(ATTACK_N);
    localparam logic [CNT_W-1:0]   RELEASE_C = CNT_W'(RELEASE_N);
    localparam logic [HOLD_W-1:0]  HOLD_C    = HOLD_W'(HOLD_N);

    logic [SAMPLE_W-1:0] mag, decayed, new_peak, peak_q;
    logic [HOLD_W-1:0]   hold_q, new_hold;
    logic [DIGIT_W-1:0]  inst_digit, peak_digit, digit_q;
    logic [CNT_W-1:0]    cnt, cnt_inc;
    vad_state_t          state;
    logic                voice_q, valid_q, loud, quiet;

    level_quantizer #(.THRESH_STEP(THRESH_STEP)) u_q_inst (.value(mag),      .digit(inst_digit));
    level_quantizer #(.THRESH_STEP(THRESH_STEP)) u_q_peak (.value(new_peak), .digit(peak_digit));

    always_comb begin
        mag      = abs_sat(bus.sample_in);
        decayed  = peak_q - (peak_q >> DECAY_SHIFT);
        new_peak = peak_q;
        new_hold = hold_q;
        if (mag >= peak_q) begin
            new_peak = mag;
            new_hold = HOLD_C;
        end else if (hold_q != '0) begin
            new_hold = hold_q - 1'b1;
        end else begin
            new_peak = (mag > decayed) ? mag : decayed;
        end
        loud    = inst_digit >= ON_D;
        quiet   = inst_digit < OFF_D;
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values together.
        if (reset) begin
            peak_q  <= '0;
            hold_q  <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.sample_valid;
            if (bus.sample_valid) begin
                peak_q  <= new_peak;
                hold_q  <= new_hold;
                digit_q <= peak_digit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            voice_q <= 1'b0;
        end else if (bus.sample_valid) begin
            unique case (state)
                IDLE: if (loud) begin
                    if (ATTACK_N == 1) begin
                        state   <= ACTIVE;
                        voice_q <= 1'b1;
                    end else begin
                        state <= ATTACK;
                        cnt   <= CNT_W'(1);
                    end
                end
                ATTACK: if (loud) begin
                    if (cnt_inc == ATTACK_C) begin
                        state   <= ACTIVE;
                        cnt     <= '0;
                        voice_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                ACTIVE: if (quiet) begin
                    if (RELEASE_N == 1) begin
                        state   <= IDLE;
                        voice_q <= 1'b0;
                    end else begin
                        state <= RELEASE;
                        cnt   <= CNT_W'(1);
                    end
                end
                RELEASE: if (quiet) begin
                    if (cnt_inc == RELEASE_C) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        voice_q <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else begin
                    state <= ACTIVE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.level_digit  = digit_q;
    assign bus.peak_mag     = peak_q;
    assign bus.voice_active = voice_q;
    assign bus.level_valid  = valid_q;

endmodule

// File: tb/tb_audio_level_detector.sv
// Directed vector table for the audio level detector plus a short
// hand-written sequence for the level_valid pulse and idle holding.
module tb_audio_level_detector;
    import audio_pkg::*;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] smp;
        logic        chk_lvl;
        logic [3:0]  dig;
        logic [31:0] pk;
        logic        voice;
        logic        lv;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    audio_level_detector_if bus ();

    audio_level_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [31:0] smp,
                       input logic chk, input logic [3:0] dig, input logic [31:0] pk,
                       input logic voice, input logic lv);
        vec_t v;
        v.rst = rst; v.vld = vld; v.smp = smp; v.chk_lvl = chk;
        v.dig = dig; v.pk = pk; v.voice = voice; v.lv = lv;
        vecs.push_back(v);
    endtask

    initial begin
        bool_found_block : begin end
    end

    initial begin
        logic found;

        bus.sample_in    = 32'h7FFF_FFFF;
        bus.sample_valid = 1'b1;

        // Reset beats a valid sample; then one loud sample.
        add(1, 1, 32'h7FFF_FFFF, 1, 0, 32'h0, 0, 0);
        add(0, 1, 32'h0500_0000, 1, 5, 32'h0500_0000, 0, 1);
        add(0, 0, 32'h0900_0000, 1, 5, 32'h0500_0000, 0, 0);
        add(0, 1, 32'h0000_0000, 1, 5, 32'h0500_0000, 0, 1);
        // Attack aborted after 3 loud samples, then a full attack (peak held).
        for (int i = 0; i < 3; i++) add(0, 1, 32'h0400_0000, 1, 5, 32'h0500_0000, 0, 1);
        add(0, 1, 32'h0000_0000, 1, 5, 32'h0500_0000, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 32'h0400_0000, 1, 5, 32'h0500_0000, 0, 1);
        add(0, 1, 32'h0400_0000, 1, 5, 32'h0500_0000, 1, 1);
        // Release aborted by a hysteresis-band sample, then a full release.
        for (int i = 0; i < 7; i++) add(0, 1, 32'h0, 0, 0, 32'h0, 1, 1);
        add(0, 1, 32'h0200_0000, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 7; i++) add(0, 1, 32'h0, 0, 0, 32'h0, 1, 1);
        add(0, 1, 32'h0, 0, 0, 32'h0, 0, 1);
        // Hold for 16 samples, then two decay steps.
        add(1, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        add(0, 1, 32'h0800_0000, 1, 8, 32'h0800_0000, 0, 1);
        for (int i = 0; i < 16; i++) add(0, 1, 32'h0, 1, 8, 32'h0800_0000, 0, 1);
        add(0, 1, 32'h0, 1, 7, 32'h0700_0000, 0, 1);
        add(0, 1, 32'h0, 1, 6, 32'h0620_0000, 0, 1);
        // Negative input, saturating most-negative input, reset out of ACTIVE.
        add(1, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        add(0, 1, 32'hF800_0000, 1, 8, 32'h0800_0000, 0, 1);
        add(0, 1, 32'h8000_0000, 1, 9, 32'h7FFF_FFFF, 0, 1);
        add(0, 1, 32'h8000_0000, 1, 9, 32'h7FFF_FFFF, 0, 1);
        add(0, 1, 32'h8000_0000, 1, 9, 32'h7FFF_FFFF, 1, 1);
        add(0, 0, 32'h0, 1, 9, 32'h7FFF_FFFF, 1, 0);
        add(1, 1, 32'h7FFF_FFFF, 1, 0, 32'h0, 0, 0);
        add(0, 0, 32'h0, 1, 0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset            = vecs[i].rst;
            bus.sample_valid = vecs[i].vld;
            bus.sample_in    = vecs[i].smp;
            @(posedge clk);
            #1;
            if (vecs[i].chk_lvl) begin
                check($sformatf("v%0d digit", i), 32'(bus.level_digit), 32'(vecs[i].dig));
                check($sformatf("v%0d peak", i), bus.peak_mag, vecs[i].pk);
            end
            check($sformatf("v%0d voice", i), 32'(bus.voice_active), 32'(vecs[i].voice));
            check($sformatf("v%0d level_valid", i), 32'(bus.level_valid), 32'(vecs[i].lv));
        end

        // One strobe, bounded wait for the pulse, then idle cycles hold outputs.
        @(negedge clk);
        reset            = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_in    = 32'h0300_0000;
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.level_valid) found = 1'b1;
            @(negedge clk);
            bus.sample_valid = 1'b0;
            bus.sample_in    = 32'h0900_0000;
        end
        check("pulse seen", 32'(found), 32'd1);
        check("pulse digit", 32'(bus.level_digit), 32'd3);
        check("pulse peak", bus.peak_mag, 32'h0300_0000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("gap%0d level_valid", c), 32'(bus.level_valid), 32'd0);
            check($sformatf("gap%0d peak", c), bus.peak_mag, 32'h0300_0000);
            check($sformatf("gap%0d digit", c), 32'(bus.level_digit), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_level_detector.md
Name: audio_level_detector

Overview:
Downstream consumer of the moving-average filter output. Takes each filtered 32-bit sample and computes its magnitude. Tracks a peak envelope with hold and exponential decay, and quantizes it to a 0-9 level digit for the 7-segment display driver. It also runs a voice-activity state machine with attack/release debounce, and the display controller uses that flag to gate digit updates.

Parameters:
THRESH_STEP, 32'h0100_0000, magnitude per digit step; digit k requires mag >= k*THRESH_STEP
ON_LEVEL, 3, instantaneous digit at/above which a sample counts as "loud"
OFF_LEVEL, 2, instantaneous digit below which a sample counts as "quiet"; must be <= ON_LEVEL
ATTACK_N, 4, consecutive loud samples needed to assert voice_active
RELEASE_N, 8, consecutive quiet samples needed to deassert voice_active
HOLD_N, 16, samples the peak is held after a new maximum before decay starts
DECAY_SHIFT, 3, per-sample decay: peak -= peak >> DECAY_SHIFT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
sample_in  in  32  filtered sample, two's complement
sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle
level_digit  out  4  quantized peak envelope, 0..9
peak_mag  out  32  current peak envelope magnitude
voice_active  out  1  debounced voice-activity flag
level_valid  out  1  one-cycle pulse; outputs updated for the last sample

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: level_digit=0, peak_mag=0, voice_active=0, level_valid=0. FSM goes to IDLE; hold and debounce counters clear to 0.
- Reset has priority over sample_valid in the same cycle. Reset mid-operation, including in ACTIVE, returns to reset values on the next edge.
- Latency: sample_valid at edge t gives updated outputs and level_valid=1 after edge t, i.e. during cycle t+1. level_valid is 1 only for the cycle after a valid sample.
- When sample_valid=0, every register holds its value and level_valid=0.
- Magnitude: mag = |sample_in|. The input 32'h8000_0000 saturates to 32'h7FFF_FFFF.
- Quantize q(x) = number of k in 1..9 with x >= k*THRESH_STEP. Compare at 36-bit width so there is no overflow. Result is clamped to 9 by construction.
- Peak update, per valid sample:
  - If mag >= peak: peak=mag and hold=HOLD_N.
  - Else if hold != 0: hold=hold-1 and peak is unchanged.
  - Else: peak = max(mag, peak - (peak >> DECAY_SHIFT)).
- level_digit = q(new peak), registered on the same edge as peak.
- FSM input is the instantaneous digit d = q(mag), not the peak. Counter cnt saturates.
  - IDLE: if d >= ON_LEVEL, go to ATTACK with cnt=1. If ATTACK_N == 1, go to ACTIVE directly.
  - ATTACK: if d >= ON_LEVEL, cnt+1; when cnt+1 == ATTACK_N, go to ACTIVE. Else go to IDLE with cnt=0.
  - ACTIVE: if d < OFF_LEVEL, go to RELEASE with cnt=1 (or to IDLE if RELEASE_N == 1). Else stay.
  - RELEASE: if d < OFF_LEVEL, cnt+1; when cnt+1 == RELEASE_N, go to IDLE. Else go back to ACTIVE with cnt=0.
  - Hysteresis band: samples with OFF_LEVEL <= d < ON_LEVEL abort ATTACK and RELEASE alike.
- voice_active = 1 in ACTIVE and RELEASE. It is registered and changes on the same edge as level_valid.

Decomposition:
- Shared package audio_pkg holds:
  - the FSM state enum (IDLE, ATTACK, ACTIVE, RELEASE, 2-bit);
  - DIGIT_W=4 and MAX_DIGIT=9;
  - SAMPLE_W=32.
  The 7-segment decoder reuses DIGIT_W and MAX_DIGIT.
- One sub-module, level_quantizer: a combinational 9-comparator chain parameterized by THRESH_STEP. It is instantiated twice, for q(mag) and q(new peak).

Test Plan:
- Reset with sample_valid=1 and sample_in=32'h7FFF_FFFF -> all outputs 0 and no level_valid pulse. Release reset, apply one valid sample of 5*2^24 -> during the next cycle level_valid=1, level_digit=5, peak_mag=32'h0500_0000.
- Apply 3 valid samples of 4*2^24, then 1 of 0 -> voice_active stays 0 and FSM returns to IDLE. Then 4 samples of 4*2^24 -> voice_active rises with the level_valid of the 4th sample.
- From ACTIVE, apply 7 samples of 0 then 1 of 2*2^24 (hysteresis band) -> voice_active stays 1. Then 8 samples of 0 -> voice_active falls with the 8th level_valid.
- Peak of 8*2^24, then samples of 0 -> peak_mag holds at 32'h0800_0000 for 16 samples. The 17th sample gives 32'h0700_0000 (digit 7), the 18th gives 32'h0620_0000 (digit 6).
- Negative input 32'hF800_0000 (-2^27) -> mag 2^27, digit 8. Input 32'h8000_0000 -> peak_mag 32'h7FFF_FFFF, digit 9.
- Drive reset for one cycle while in ACTIVE with peak at digit 9 -> next cycle voice_active=0, level_digit=0, peak_mag=0. Idle gaps with sample_valid=0 between samples -> outputs unchanged and level_valid stays 0.
